// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and defaults for the USB receive bit front end
package usb_rx_pkg;

  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_SE0, RX_EOP} rx_fe_state_t;

  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_SAMPLE_OFFSET = 3;
  localparam int DEF_STUFF_LIMIT   = 6;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      2'b00:   return LS_SE0;
      default: return LS_SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - modulo bit-time counter with edge resync
// Held at zero while disabled; a line edge restarts the bit at count 1.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_OFFSET = DEF_SAMPLE_OFFSET
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic resync,
  output logic sample_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SAMP = CW'(SAMPLE_OFFSET);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (resync) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_tick = (cnt_q == CNT_SAMP) && enable;

endmodule

// File: rtl/usb_rx_bit_frontend.sv
// rtl/usb_rx_bit_frontend.sv - USB receive front end: edge detect, NRZI decode, unstuff, byte assembly
// Emits d_edge, byte_complete, eop and stuff_error strobes for the receive control unit.
module usb_rx_bit_frontend
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_OFFSET = DEF_SAMPLE_OFFSET,
  parameter int STUFF_LIMIT   = DEF_STUFF_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       enable_timer,
  output logic       d_edge,
  output logic       byte_complete,
  output logic [7:0] rx_byte,
  output logic       eop,
  output logic       stuff_error
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);
  localparam logic [OW-1:0] ONES_ONE = OW'(1);

  rx_fe_state_t state_q, state_d;
  logic          dp_q, dp_d;
  logic          d_edge_q, d_edge_d;
  logic          prev_dp_q, prev_dp_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          byte_complete_q, byte_complete_d;
  logic          eop_q, eop_d;
  logic          stuff_error_q, stuff_error_d;

  logic        raw_edge;
  logic        sample_tick;
  line_state_t line_state;
  logic        is_se0;
  logic        is_j;
  logic        nrzi_bit;
  logic        take_bit;

  assign raw_edge   = (d_plus != dp_q);
  assign line_state = decode_line(d_plus, d_minus);
  assign is_se0     = (line_state == LS_SE0);
  assign is_j       = (line_state == LS_J);
  assign nrzi_bit   = (d_plus == prev_dp_q);

  usb_rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_OFFSET(SAMPLE_OFFSET)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable_timer),
    .resync     (raw_edge),
    .sample_tick(sample_tick)
  );

  always_comb begin
    state_d         = state_q;
    dp_d            = d_plus;
    d_edge_d        = raw_edge;
    prev_dp_d       = prev_dp_q;
    ones_d          = ones_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    byte_complete_d = 1'b0;
    eop_d           = 1'b0;
    stuff_error_d   = 1'b0;
    take_bit        = 1'b0;

    if (!enable_timer) begin
      state_d   = RX_IDLE;
      prev_dp_d = 1'b1;
      ones_d    = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      unique case (state_q)
        RX_IDLE, RX_BITS: begin
          state_d = RX_BITS;
          if (sample_tick) begin
            if (is_se0) begin
              state_d = RX_SE0;
              ones_d  = '0;
            end else begin
              take_bit = 1'b1;
            end
          end
        end
        RX_SE0: begin
          if (sample_tick) begin
            if (is_se0) begin
              state_d   = RX_EOP;
              eop_d     = 1'b1;
              bit_cnt_d = '0;
              ones_d    = '0;
            end else begin
              state_d  = RX_BITS;
              take_bit = 1'b1;
            end
          end
        end
        RX_EOP: begin
          // Lingering SE0 is ignored so eop fires once per packet.
          if (sample_tick && is_j) begin
            state_d   = RX_BITS;
            prev_dp_d = 1'b1;
            bit_cnt_d = '0;
            ones_d    = '0;
          end
        end
        default: state_d = RX_IDLE;
      endcase

      if (take_bit) begin
        prev_dp_d = d_plus;
        if (ones_q == ONES_MAX) begin
          ones_d        = '0;
          stuff_error_d = nrzi_bit;
        end else begin
          ones_d  = nrzi_bit ? (ones_q + ONES_ONE) : '0;
          shift_d = {nrzi_bit, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d       = shift_d;
            byte_complete_d = 1'b1;
            bit_cnt_d       = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RX_IDLE;
      dp_q            <= 1'b1;
      d_edge_q        <= 1'b0;
      prev_dp_q       <= 1'b1;
      ones_q          <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      byte_complete_q <= 1'b0;
      eop_q           <= 1'b0;
      stuff_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      dp_q            <= dp_d;
      d_edge_q        <= d_edge_d;
      prev_dp_q       <= prev_dp_d;
      ones_q          <= ones_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      byte_complete_q <= byte_complete_d;
      eop_q           <= eop_d;
      stuff_error_q   <= stuff_error_d;
    end
  end

  assign d_edge        = d_edge_q;
  assign byte_complete = byte_complete_q;
  assign rx_byte       = rx_byte_q;
  assign eop           = eop_q;
  assign stuff_error   = stuff_error_q;

endmodule

// File: tb/tb_usb_rx_bit_frontend.sv
// tb/tb_usb_rx_bit_frontend.sv - self-checking bench for usb_rx_bit_frontend
// Packets are NRZI/stuff encoded into line symbols and compared against a symbol-level decoder.
module tb_usb_rx_bit_frontend;

  localparam int STUFF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_plus;
  logic       d_minus;
  logic       enable_timer;
  logic       d_edge;
  logic       byte_complete;
  logic [7:0] rx_byte;
  logic       eop;
  logic       stuff_error;

  always #5 clk = ~clk;

  usb_rx_bit_frontend dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .byte_complete(byte_complete),
    .rx_byte      (rx_byte),
    .eop          (eop),
    .stuff_error  (stuff_error)
  );

  typedef struct {
    logic [7:0] d0, d1, d2;
    int nd;
    int mode;
    int bad;
    int partial;
    int se0;
    int glitch;
    int exp_nb;
    int exp_serr;
    int exp_eop;
  } row_t;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] mon_bytes[$];
  time        mon_bt[$];
  time        mon_et[$];
  int         n_eop  = 0;
  int         n_serr = 0;

  always @(negedge clk) begin
    if (byte_complete === 1'b1) begin
      mon_bytes.push_back(rx_byte);
      mon_bt.push_back($time);
    end
    if (eop === 1'b1) n_eop++;
    if (stuff_error === 1'b1) n_serr++;
    if (d_edge === 1'b1) mon_et.push_back($time);
  end

  logic [1:0] sym_q[$];
  time        sym_t[$];
  logic       enc_level;
  int         enc_ones;
  int         enc_stuffs;
  int         enc_bad;

  logic [7:0] exp_bytes[$];
  int         exp_serr;
  int         exp_eop;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic enc_bit(input logic b);
    if (!b) enc_level = ~enc_level;
    sym_q.push_back({enc_level, ~enc_level});
    enc_ones = b ? enc_ones + 1 : 0;
    if (enc_ones == STUFF) begin
      enc_stuffs++;
      if (enc_stuffs != enc_bad) enc_level = ~enc_level;
      sym_q.push_back({enc_level, ~enc_level});
      enc_ones = 0;
    end
  endtask

  task automatic build(input row_t r);
    logic [7:0] bytes [4];
    logic [7:0] pat;
    int         nfull;
    logic       b;
    sym_q.delete();
    sym_t.delete();
    enc_level  = 1'b1;
    enc_ones   = 0;
    enc_stuffs = 0;
    enc_bad    = r.bad;
    bytes[0] = 8'h80;
    bytes[1] = r.d0;
    bytes[2] = r.d1;
    bytes[3] = r.d2;
    pat   = 8'hA5;
    nfull = 8 * (1 + r.nd);
    for (int i = 0; i < nfull + r.partial; i++) begin
      if (i == r.glitch) begin
        sym_q.push_back(2'b00);
        enc_ones = 0;
      end
      if (i < nfull) b = bytes[i/8][i%8];
      else b = pat[i-nfull];
      enc_bit(b);
    end
    for (int i = 0; i < r.se0; i++) sym_q.push_back(2'b00);
    if (r.se0 > 0) begin
      sym_q.push_back(2'b10);
      sym_q.push_back(2'b10);
    end
  endtask

  // One sample per line symbol; trailing partial bits vanish when enable drops.
  task automatic run_model();
    logic       prev, dp, dm, bitv;
    logic [7:0] acc;
    int         ones, nb, se0_run;
    bit         in_eop;
    exp_bytes.delete();
    exp_serr = 0;
    exp_eop  = 0;
    prev = 1'b1; acc = 8'h00; ones = 0; nb = 0; se0_run = 0; in_eop = 0;
    foreach (sym_q[i]) begin
      dp = sym_q[i][1];
      dm = sym_q[i][0];
      if (in_eop) begin
        if (dp && !dm) begin
          in_eop = 0; prev = 1'b1; nb = 0; ones = 0;
        end
        continue;
      end
      if (!dp && !dm) begin
        se0_run++;
        ones = 0;
        if (se0_run == 2) begin
          exp_eop++; in_eop = 1; nb = 0; se0_run = 0;
        end
        continue;
      end
      se0_run = 0;
      bitv = (dp == prev);
      prev = dp;
      if (ones == STUFF) begin
        ones = 0;
        if (bitv) exp_serr++;
        continue;
      end
      ones = bitv ? ones + 1 : 0;
      acc  = {bitv, acc[7:1]};
      nb++;
      if (nb == 8) begin
        exp_bytes.push_back(acc);
        nb = 0;
      end
    end
  endtask

  task automatic drive(input int mode, input int stop_at);
    for (int i = 0; i < sym_q.size(); i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      {d_plus, d_minus} = sym_q[i];
      enable_timer = 1'b1;
      sym_t.push_back($time);
      repeat ((mode != 0) ? (((i % 2) != 0) ? 9 : 7) : 8) @(negedge clk);
    end
    enable_timer = 1'b0;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_model(input string tag, input int b0, input int e0, input int s0);
    int nb;
    nb = mon_bytes.size() - b0;
    chk({tag, "_nbytes_model"}, nb, exp_bytes.size());
    for (int i = 0; i < nb && i < exp_bytes.size(); i++)
      chk($sformatf("%s_byte%0d_model", tag, i), mon_bytes[b0+i], exp_bytes[i]);
    chk({tag, "_serr_model"}, n_serr - s0, exp_serr);
    chk({tag, "_eop_model"}, n_eop - e0, exp_eop);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t       rows[9];
    row_t       r;
    int         b0, e0, s0, nb, eb0;
    logic [7:0] tbl[4];
    time        tt[8];
    int         lat;

    rows[0] = '{8'hE1, 8'h00, 8'h00, 1, 0, 0, 0, 0, -1, 2, 0, 0};
    rows[1] = '{8'hFF, 8'hFF, 8'h00, 2, 0, 0, 0, 0, -1, 3, 0, 0};
    rows[2] = '{8'hFF, 8'hFF, 8'h00, 2, 0, 1, 0, 0, -1, 3, 1, 0};
    rows[3] = '{8'hE1, 8'h3C, 8'h00, 2, 0, 0, 3, 2, -1, 3, 0, 1};
    rows[4] = '{8'h5A, 8'h00, 8'h00, 1, 0, 0, 0, 0, 12, 2, 0, 0};
    rows[5] = '{8'hA5, 8'hFF, 8'h0F, 3, 1, 0, 0, 0, -1, 4, 0, 0};
    rows[6] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 4, 0, -1, 1, 0, 0};
    rows[7] = '{8'hC3, 8'h00, 8'h00, 1, 0, 0, 0, 0, -1, 2, 0, 0};
    rows[8] = '{8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 3, -1, 2, 0, 1};

    rst = 1'b1; d_plus = 1'b1; d_minus = 1'b0; enable_timer = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_byte_complete", byte_complete, 1'b0);
    chk("reset_eop", eop, 1'b0);
    chk("reset_stuff_error", stuff_error, 1'b0);
    chk("reset_d_edge", d_edge, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      r = rows[k];
      build(r);
      run_model();
      b0 = mon_bytes.size(); e0 = n_eop; s0 = n_serr;
      drive(r.mode, -1);
      tbl[0] = 8'h80; tbl[1] = r.d0; tbl[2] = r.d1; tbl[3] = r.d2;
      nb = mon_bytes.size() - b0;
      chk($sformatf("row%0d_nbytes", k), nb, r.exp_nb);
      for (int i = 0; i < nb && i < r.exp_nb; i++)
        chk($sformatf("row%0d_byte%0d", k, i), mon_bytes[b0+i], tbl[i]);
      chk($sformatf("row%0d_serr", k), n_serr - s0, r.exp_serr);
      chk($sformatf("row%0d_eop", k), n_eop - e0, r.exp_eop);
      compare_model($sformatf("row%0d", k), b0, e0, s0);
      if (k == 0) begin
        lat = (mon_bt.size() > b0) ? int'(mon_bt[b0] - sym_t[7]) : -1;
        chk("sync_latency", lat, 40);
        lat = (mon_bt.size() > b0 + 1) ? int'(mon_bt[b0+1] - sym_t[15]) : -1;
        chk("pid_latency", lat, 40);
      end
      repeat (5) @(negedge clk);
    end

    // Reset in the middle of the second byte.
    build(rows[0]);
    b0 = mon_bytes.size(); e0 = n_eop;
    drive(0, 12);
    chk("pre_reset_rx_byte", rx_byte, 8'h80);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rx_byte", rx_byte, 8'h00);
    chk("midrst_byte_complete", byte_complete, 1'b0);
    chk("midrst_eop", eop, 1'b0);
    chk("midrst_stuff_error", stuff_error, 1'b0);
    chk("midrst_d_edge", d_edge, 1'b0);
    @(negedge clk);
    enable_timer = 1'b0; d_plus = 1'b1; d_minus = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_nbytes", mon_bytes.size() - b0, 1);
    chk("midrst_no_eop", n_eop - e0, 0);

    // Idle line toggling with bit timing disabled.
    eb0 = mon_et.size(); b0 = mon_bytes.size(); e0 = n_eop; s0 = n_serr;
    for (int i = 0; i < 8; i++) begin
      d_plus  = ~d_plus;
      d_minus = ~d_plus;
      tt[i]   = $time;
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("idle_edges", mon_et.size() - eb0, 8);
    for (int i = 0; i < 8 && eb0 + i < mon_et.size(); i++)
      chk($sformatf("idle_edge%0d_time", i), int'(mon_et[eb0+i] - tt[i]), 10);
    chk("idle_bytes", mon_bytes.size() - b0, 0);
    chk("idle_eop", n_eop - e0, 0);
    chk("idle_serr", n_serr - s0, 0);
    d_plus = 1'b1; d_minus = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      r.nd = $urandom_range(1, 3);
      r.d0 = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      r.d1 = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      r.d2 = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      r.mode    = $urandom_range(0, 1);
      r.bad     = $urandom_range(0, 2);
      r.partial = $urandom_range(0, 7);
      r.se0     = 2 * $urandom_range(0, 1);
      r.glitch  = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 8 * (1 + r.nd) + r.partial - 1) : -1;
      build(r);
      run_model();
      b0 = mon_bytes.size(); e0 = n_eop; s0 = n_serr;
      drive(r.mode, -1);
      compare_model($sformatf("rand%0d", k), b0, e0, s0);
      repeat (5) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_rx_bit_frontend.md
Name: usb_rx_bit_frontend

Overview:
- Upstream stage of the USB receiver control unit.
- Takes synchronized D+/D- line samples. Produces bit-timing-recovered, NRZI-decoded, bit-unstuffed bytes.
- Generates the d_edge, byte_complete and eop strobes that the control unit sequences on, plus rx_byte for the data buffer.
- Sample timing is gated by the control unit's enable_timer.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time; range 4..16.
- SAMPLE_OFFSET, 3, clock-count value within a bit at which the line is sampled; must be < CLKS_PER_BIT.
- STUFF_LIMIT, 6, consecutive decoded 1s after which a stuffed 0 is expected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- d_plus  in  1  D+ line, already 2-flop synchronized.
- d_minus  in  1  D- line, already 2-flop synchronized.
- enable_timer  in  1  from control unit; 1 = packet in progress, bit timing runs.
- d_edge  out  1  one-cycle pulse on any change of d_plus.
- byte_complete  out  1  one-cycle pulse when rx_byte holds a new byte.
- rx_byte  out  8  last assembled byte, LSB = first received bit.
- eop  out  1  one-cycle pulse on detected end-of-packet.
- stuff_error  out  1  one-cycle pulse on a bit-stuff violation.

Behaviour:
- Reset: all outputs 0; rx_byte = 8'h00; bit-clock counter 0; bit count 0; ones count 0; prev_dp = 1 (J); FSM = RX_IDLE.
- Edge detect: dp_q registers d_plus each cycle. d_edge = registered (d_plus != dp_q). d_edge runs regardless of enable_timer.
- Bit clock: counter held at 0 while enable_timer = 0. Otherwise it counts 0..CLKS_PER_BIT-1 and wraps. A raw edge (d_plus != dp_q) forces the counter to 1 on the next cycle (resync). sample_tick = (counter == SAMPLE_OFFSET) && enable_timer.
- Line state at sample: SE0 if d_plus = 0 and d_minus = 0; otherwise data.
- NRZI: decoded bit = 1 if d_plus == prev_dp, else 0. prev_dp is updated on every data sample.
- Unstuffing:
  - ones count increments on decoded 1 and clears on decoded 0.
  - When ones count == STUFF_LIMIT, the next data sample is discarded and ones count clears.
  - If that discarded bit is 1, stuff_error pulses the cycle after the sample.
- Assembly: each kept bit shifts in at MSB (shift right), LSB-first on the wire.
  - On the 8th kept bit, rx_byte is loaded and byte_complete pulses on the cycle after that sample tick (latency 1 clock from the sample).
  - Bit count then returns to 0. rx_byte holds until the next byte_complete.
- FSM states:
  - RX_IDLE: enable_timer = 0; counters cleared; prev_dp = 1. Go to RX_BITS when enable_timer = 1.
  - RX_BITS: on SE0 sample go to RX_SE0; the SE0 bit is not shifted and ones count clears.
  - RX_SE0: on a second consecutive SE0 sample go to RX_EOP and pulse eop the next cycle. On a data sample, treat it as a glitch: return to RX_BITS and process the bit normally.
  - RX_EOP: wait for a J sample (d_plus = 1, d_minus = 0), then go to RX_BITS with prev_dp = 1 and bit count 0. Further SE0 samples are ignored (eop pulses once per packet).
  - Any state: enable_timer = 0 goes to RX_IDLE next cycle. A partial byte is discarded, and byte_complete/eop are not generated for it.
- Simultaneous events:
  - 8th bit sampled in the same cycle enable_timer drops: the byte is still completed.
  - EOP arriving with bit count != 0: partial byte dropped, no byte_complete.
  - Stuff error: does not stop reception; bit count is unaffected.
- Reset mid-packet: immediate return to reset values; no pulses emitted.

Decomposition:
- Package usb_rx_pkg:
  - line_state_t enum {LS_J, LS_K, LS_SE0, LS_SE1}.
  - rx_fe_state_t enum {RX_IDLE, RX_BITS, RX_SE0, RX_EOP}.
  - Default constants for CLKS_PER_BIT, SAMPLE_OFFSET, STUFF_LIMIT.
- Sub-module usb_rx_bit_timer: resettable, resyncable modulo counter producing sample_tick. Everything else lives in the top.

Test Plan:
- Sync then PID, with CLKS_PER_BIT = 8 and enable_timer = 1:
  - Drive KJKJKJKK (d_plus 0,1,0,1,0,1,0,0) -> byte_complete once, rx_byte = 8'h80, 1 clock after the 8th sample.
  - Continue with the PID bits for 8'hE1 -> second byte_complete with rx_byte = 8'hE1.
- Stuffing: send data 8'hFF, 8'hFF with a correct stuffed 0 after each run of six 1s -> two byte_completes, both 8'hFF, stuff_error = 0.
  - Repeat with the stuffed bit as 1 -> stuff_error pulses exactly once; the byte count stays correct.
- EOP:
  - After 2 bytes, drive SE0 for 2 bit times then J -> exactly one eop pulse; no byte_complete for the trailing partial bits.
  - A single-bit SE0 glitch -> no eop.
- Clock drift: the line period alternates 7 and 9 clocks per bit over 3 bytes -> correct bytes received via edge resync; no extra or missing byte_complete.
- Abort/reset:
  - enable_timer drops after 4 bits of a byte -> no byte_complete; the next packet decodes from bit 0.
  - rst asserted mid-byte -> all outputs 0 that cycle; rx_byte = 8'h00.
- Idle: enable_timer = 0 with the line toggling -> d_edge pulses on every toggle; byte_complete, eop and stuff_error stay 0.
